f32m_cube_pow: RTL and testbench
================================

// Module: f32m_cube_pow
// PURPOSE
//  Iterative Frobenius engine for GF(3^{2M}): computes c = a^(3^n) by applying the GF(3^{2M}) cube map n times.
//  One cube is applied per clock, with a start/done handshake. The cube map is (a0 + a1*s)^3 = a0^3 - a1^3*s,
//  built from the f3m_cubic and f3m_neg combinational cells.
//  Sits downstream of the single-shot f32m_cubic stage; the final-exponentiation controller uses it for x^(3^k) powers.
// PARAMETERS
//  NW   8   width of exponent count n (max n = 2^NW-1)
//  M    97  field degree, fixed by `M; element widths follow `WIDTH/`W2
// PORTS
//  clk      in   1       rising-edge clock
//  reset_n  in   1       asynchronous, active-low reset
//  start    in   1       request; sampled only in IDLE
//  n        in   NW      number of cube applications; sampled with start
//  a        in   `W2+1   operand {a1,a0}, 2 bits per trit; sampled with start
//  busy     out  1       high in RUN and DONE
//  done     out  1       one-cycle pulse; c is valid while done is high
//  c        out  `W2+1   result register {c1,c0}; holds its value until the next accepted start
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, r=0, cnt=0, busy=0, done=0, c=0. Takes effect immediately, including mid-RUN.
//    No partial result survives.
//  - State IDLE:
//    - start=1 at an edge: r<=a, cnt<=n_eff.
//    - Next state is RUN if n_eff!=0, else DONE.
//    - start=0: stay in IDLE, r holds.
//  - State RUN, each edge:
//    - r<={-(r1^3), r0^3}; cnt<=cnt-1.
//    - If cnt==1, next state is DONE; otherwise stay in RUN.
//    - cnt is never 0 in RUN.
//  - State DONE: done=1 and busy=1 for exactly one cycle, c=r. Next state is IDLE unconditionally.
//  - Latency: done is high in the cycle after edge n_eff+1, counted from the edge that sampled start.
//    n_eff=0 gives done one cycle after start and c=a.
//  - Outputs:
//    - done is decoded from state DONE.
//    - busy = (state!=IDLE).
//    - c is driven directly from r. It is stable from DONE until the next accepted start.
//  - start while busy=1 is ignored, with no queueing. start in the DONE cycle is also ignored.
//    start may be re-asserted in the IDLE cycle that follows DONE.
//  - Arithmetic:
//    - Trit encoding per 2-bit slice: 00=0, 01=1, 10=2; 11 never generated.
//    - Negation swaps the two bits of each slice.
//    - No carries cross trit boundaries.
//  - a and n need not be held after the sampling edge.
//  - cnt is an NW-bit down counter with no wrap: it is loaded only from n_eff and decremented only in RUN.
// CONFIGURATION
//  F32M_CUBE_POW_ORDER_REDUCE_EN
//  - Defined: n_eff = (n >= 2M) ? n-2M : n, with 2M=194. This is valid because a^(3^(2M)) = a.
//    Requires n < 4M; the condition holds for NW<=8.
//    Example: n=194 gives n_eff=0, so done arrives 1 cycle after start.
//  - Undefined: n_eff = n, and all n cube steps are executed.
//  - The result c is identical in both builds; only latency differs.
// TESTING
//  T1 n=0, a={194'h5,194'h9} -> done 1 cycle after start; c={194'h5,194'h9}.
//  T2 n=1, a={194'h1,194'h4} (a1=1, a0=x) -> done after 2 edges; c={194'h2,194'h40} (-1, x^3); busy high 2 cycles.
//  T3 n=2, a={194'h1,194'h4} -> done after 3 edges; c={194'h1,194'h40000} (+1, x^9).
//  T4 n=194, random a -> c==a. With _EN: done after 1 edge. Without: done after 195 edges.
//  T5 start pulsed during RUN with a different a and n -> ignored; result and latency are those of the first request.
//     Back-to-back start in the IDLE cycle after DONE is accepted.
//  T6 reset_n low mid-RUN (n=10, at edge 4) -> busy, done and c are 0 immediately;
//     done is never asserted for that request. A fresh start after release is processed correctly.

Source files
------------

// File: rtl/f32m_cube_pow_if.sv
// Handshake bundle for f32m_cube_pow: start/n/a request side, busy/done/c result side.
`timescale 1ns/1ps
interface f32m_cube_pow_if #(
  parameter int NW = 8,
  parameter int AW = 388
);
  logic          start;
  logic [NW-1:0] n;
  logic [AW-1:0] a;
  logic          busy;
  logic          done;
  logic [AW-1:0] c;

  modport master (output start, n, a, input  busy, done, c);
  modport slave  (input  start, n, a, output busy, done, c);
endinterface

// File: rtl/f32m_cube_pow.sv
// Iterative Frobenius engine for GF(3^194): c = a^(3^n), one cube map per clock.
// Optional macro F32M_CUBE_POW_ORDER_REDUCE_EN folds n >= 194 down by the field order.
`timescale 1ns/1ps
module f32m_cube_pow #(
  parameter int NW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  f32m_cube_pow_if.slave  bus
);
  localparam int unsigned M   = 97;
  localparam int unsigned EW  = 2 * M;
  localparam int unsigned AW  = 2 * EW;
  localparam int unsigned DEG = 3 * (M - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   r_q, r_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   n_eff;

  function automatic logic [1:0] trit_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [EW-1:0] f3m_neg(input logic [EW-1:0] x);
    logic [EW-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < M; i++)
      y[2*i +: 2] = {x[2*i], x[2*i+1]};
    return y;
  endfunction

  // Cube in GF(3^97) mod x^97 + x^12 + 2: spread trits to 3i, then fold
  // top-down using x^97 = 2x^12 + 1 (folded terms may land above 96 again).
  function automatic logic [EW-1:0] f3m_cubic(input logic [EW-1:0] x);
    logic [1:0]    t [DEG+1];
    logic [EW-1:0] y;
    for (int unsigned i = 0; i <= DEG; i++)
      t[i] = '0;
    for (int unsigned i = 0; i < M; i++)
      t[3*i] = x[2*i +: 2];
    for (int unsigned d = DEG; d >= M; d--) begin
      t[d-(M-12)] = trit_add(t[d-(M-12)], {t[d][0], t[d][1]});
      t[d-M]      = trit_add(t[d-M], t[d]);
    end
    y = '0;
    for (int unsigned i = 0; i < M; i++)
      y[2*i +: 2] = t[i];
    return y;
  endfunction

  always_comb begin
`ifdef F32M_CUBE_POW_ORDER_REDUCE_EN
    n_eff = (32'(bus.n) >= 2 * M) ? NW'(32'(bus.n) - 2 * M) : bus.n;
`else
    n_eff = bus.n;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          r_d     = bus.a;
          cnt_d   = n_eff;
          state_d = (n_eff != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        r_d   = {f3m_neg(f3m_cubic(r_q[AW-1:EW])), f3m_cubic(r_q[EW-1:0])};
        cnt_d = cnt_q - NW'(1);
        if (cnt_q == NW'(1))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
    bus.c    = r_q;
  end

endmodule

// File: tb/tb_f32m_cube_pow.sv
// Directed self-checking bench for f32m_cube_pow (hand-computed GF(3^194) results).
`timescale 1ns/1ps
module tb_f32m_cube_pow;
  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  f32m_cube_pow_if #(.NW(8), .AW(388)) bus ();

  f32m_cube_pow #(.NW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [387:0] obs, input logic [387:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges from the accepting edge until done is seen; after the first
  // edge the request inputs are replaced by (hold, nalt, aalt).
  task automatic wait_done(input int limit, input logic hold, input logic [7:0] nalt,
                           input logic [387:0] aalt, output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    do begin
      @(posedge clk); #1;
      if (cycles == 0) begin
        bus.start = hold;
        bus.n     = nalt;
        bus.a     = aalt;
      end
      cycles++;
      if (bus.busy === 1'b1) busy_cycles++;
    end while (bus.done !== 1'b1 && cycles < limit);
    chk("done_seen", 388'(bus.done), 388'd1);
  endtask

  function automatic logic [387:0] rand_elem();
    logic [387:0] r;
    r = '0;
    for (int i = 0; i < 194; i++)
      r[2*i +: 2] = 2'($urandom_range(2));
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bc, seen;
    logic [387:0] va, vb, ra, exp_c;
    int exp_lat;

    va = {194'h1, 194'h4};
    vb = {194'h5, 194'h9};
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.n = '0;
    bus.a = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 388'(bus.busy), 388'd0);
    chk("rst_done", 388'(bus.done), 388'd0);
    chk("rst_c", bus.c, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // T1: n=0 passes a straight through
    bus.start = 1'b1; bus.n = 8'd0; bus.a = vb;
    wait_done(400, 1'b0, 8'd0, '0, cyc, bc);
    chk("t1_lat", 388'(cyc), 388'd1);
    chk("t1_c", bus.c, vb);
    @(posedge clk); #1;
    chk("t1_idle_busy", 388'(bus.busy), 388'd0);
    chk("t1_c_hold", bus.c, vb);

    // T2: one cube
    bus.start = 1'b1; bus.n = 8'd1; bus.a = va;
    wait_done(400, 1'b0, 8'd0, '0, cyc, bc);
    chk("t2_lat", 388'(cyc), 388'd2);
    chk("t2_busy_cycles", 388'(bc), 388'd2);
    chk("t2_c", bus.c, {194'h2, 194'h40});
    @(posedge clk); #1;

    // T3: two cubes
    bus.start = 1'b1; bus.n = 8'd2; bus.a = va;
    wait_done(400, 1'b0, 8'd0, '0, cyc, bc);
    chk("t3_lat", 388'(cyc), 388'd3);
    chk("t3_c", bus.c, {194'h1, 194'h40000});
    @(posedge clk); #1;

    // Reduction: a1=x^33 -> -(2x^14+x^2), a0=x^65 -> x^25+x^13+x
    bus.start = 1'b1; bus.n = 8'd1;
    bus.a = {(194'd1 << 66), (194'd1 << 130)};
    wait_done(400, 1'b0, 8'd0, '0, cyc, bc);
    chk("red_c1", 388'(bus.c[387:194]), 388'((194'd1 << 28) | (194'd1 << 5)));
    chk("red_c0", 388'(bus.c[193:0]), 388'((194'd1 << 50) | (194'd1 << 26) | (194'd1 << 2)));
    @(posedge clk); #1;

    // T4: n=194 is the identity
    ra = rand_elem();
    bus.start = 1'b1; bus.n = 8'd194; bus.a = ra;
`ifdef F32M_CUBE_POW_ORDER_REDUCE_EN
    exp_lat = 1;
`else
    exp_lat = 195;
`endif
    wait_done(400, 1'b0, 8'd0, '0, cyc, bc);
    chk("t4_lat", 388'(cyc), 388'(exp_lat));
    chk("t4_c", bus.c, ra);
    @(posedge clk); #1;

    // n=195 equals a single cube
    bus.start = 1'b1; bus.n = 8'd195; bus.a = va;
    wait_done(400, 1'b0, 8'd0, '0, cyc, bc);
    chk("n195_lat", 388'(cyc), 388'(exp_lat + 1));
    chk("n195_c", bus.c, {194'h2, 194'h40});
    @(posedge clk); #1;

    // T5: start held high through RUN and DONE with a different request
    exp_c = {194'h2, 194'h40000000000000};
    bus.start = 1'b1; bus.n = 8'd3; bus.a = va;
    wait_done(400, 1'b1, 8'd0, vb, cyc, bc);
    chk("t5_lat", 388'(cyc), 388'd4);
    chk("t5_c", bus.c, exp_c);
    @(posedge clk); #1;
    chk("t5_done_start_ignored", 388'(bus.busy), 388'd0);
    chk("t5_c_hold", bus.c, exp_c);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t5_b2b_done", 388'(bus.done), 388'd1);
    chk("t5_b2b_c", bus.c, vb);
    @(posedge clk); #1;

    // T6: asynchronous reset mid-RUN
    bus.start = 1'b1; bus.n = 8'd10; bus.a = va;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_busy_pre", 388'(bus.busy), 388'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_busy", 388'(bus.busy), 388'd0);
    chk("t6_done", 388'(bus.done), 388'd0);
    chk("t6_c", bus.c, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("t6_no_done", 388'(seen), 388'd0);
    bus.start = 1'b1; bus.n = 8'd2; bus.a = va;
    wait_done(400, 1'b0, 8'd0, '0, cyc, bc);
    chk("t6_fresh_lat", 388'(cyc), 388'd3);
    chk("t6_fresh_c", bus.c, {194'h1, 194'h40000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
